// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state encoding and GF(2^8) helpers for the inverse cipher.
package aes_pkg;

   localparam int BLOCK_W = 128;
   localparam logic [3:0] NR = 4'd10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      KEXP  = 3'd1,
      INIT  = 3'd2,
      ROUND = 3'd3,
      FINAL = 3'd4,
      DONE  = 3'd5
   } state_t;

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      case (rnd)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul11(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul13(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul14(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
              gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
              gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
              gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)};
   endfunction

   // Row r rotates right by r columns; byte index is row + 4*column.
   function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
      logic [BLOCK_W-1:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, one byte, combinational table lookup.
module aes_inv_sbox (
   input  logic [7:0] a,
   output logic [7:0] q
);

   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   logic [10:0] base;

   assign base = 11'd2047 - {a, 3'b000};
   assign q    = INV_SBOX[base -: 8];

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, combinational table lookup.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] q
);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [10:0] base;

   assign base = 11'd2047 - {a, 3'b000};
   assign q    = SBOX[base -: 8];

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: expands the key forward to round 10,
// then decrypts one round per clock while unrolling the schedule backward.
//
// state | meaning
// IDLE  | waiting for start
// KEXP  | forward key expansion, rk -> round key 10
// INIT  | initial AddRoundKey with rk10, step rk back to rk9
// ROUND | nine full inverse rounds, rk walks back to rk0
// FINAL | last round without InvMixColumns, result registered
// DONE  | result held, new start accepted
module aes128_decrypt_iter
   import aes_pkg::*;
#(
   parameter bit DONE_PULSE = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [BLOCK_W-1:0] ciphertext,
   input  logic [BLOCK_W-1:0] key,
   output logic [BLOCK_W-1:0] plaintext,
   output logic               busy,
   output logic               done
);

   state_t             state;
   logic [BLOCK_W-1:0] st;
   logic [BLOCK_W-1:0] rk;
   logic [3:0]         rnd;

   logic [31:0]        w0, w1, w2, w3;
   logic [31:0]        sw_src, sw_rot, sw_out, rcon_word;
   logic [31:0]        f0, f1, f2, f3;
   logic [BLOCK_W-1:0] rk_fwd, rk_inv;
   logic [BLOCK_W-1:0] isr, isb, add, round_out;

   assign {w0, w1, w2, w3} = rk;
   assign rcon_word        = {rcon(rnd), 24'h000000};

   // One SubWord serves both directions: forward uses w3, backward the recovered w3p.
   assign sw_src = (state == KEXP) ? w3 : (w3 ^ w2);
   assign sw_rot = {sw_src[23:0], sw_src[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_subword
      aes_sbox u_sbox (
         .a (sw_rot[31-8*g -: 8]),
         .q (sw_out[31-8*g -: 8])
      );
   end

   assign f0     = w0 ^ sw_out ^ rcon_word;
   assign f1     = w1 ^ f0;
   assign f2     = w2 ^ f1;
   assign f3     = w3 ^ f2;
   assign rk_fwd = {f0, f1, f2, f3};
   assign rk_inv = {w0 ^ sw_out ^ rcon_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};

   assign isr = inv_shift_rows(st);

   for (genvar g = 0; g < 16; g++) begin : g_inv_sub
      aes_inv_sbox u_inv_sbox (
         .a (isr[127-8*g -: 8]),
         .q (isb[127-8*g -: 8])
      );
   end

   assign add = isb ^ rk;

   always_comb begin
      round_out = '0;
      for (int c = 0; c < 4; c++) begin
         round_out[127-32*c -: 32] = inv_mix_col(add[127-32*c -: 32]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         st        <= '0;
         rk        <= '0;
         rnd       <= '0;
         plaintext <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  st    <= ciphertext;
                  rk    <= key;
                  rnd   <= 4'd1;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  state <= KEXP;
               end else if (DONE_PULSE) begin
                  done <= 1'b0;
               end
            end
            KEXP: begin
               rk <= rk_fwd;
               if (rnd == NR) begin
                  state <= INIT;
               end else begin
                  rnd <= rnd + 4'd1;
               end
            end
            INIT: begin
               st    <= st ^ rk;
               rk    <= rk_inv;
               rnd   <= rnd - 4'd1;
               state <= ROUND;
            end
            ROUND: begin
               st  <= round_out;
               rk  <= rk_inv;
               rnd <= rnd - 4'd1;
               if (rnd == 4'd1) begin
                  state <= FINAL;
               end
            end
            FINAL: begin
               plaintext <= add;
               busy      <= 1'b0;
               done      <= 1'b1;
               state     <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for aes128_decrypt_iter: known-answer vectors plus random blocks produced
// by an independent AES-128 encryption model built from GF(2^8) arithmetic.
module tb_aes128_decrypt_iter;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [127:0] ct;
   logic [127:0] key;
   logic [127:0] pt_lvl, pt_pls;
   logic         busy_lvl, busy_pls;
   logic         done_lvl, done_pls;

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [7:0]   sb [256];

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   always #5 clk = ~clk;

   aes128_decrypt_iter #(.DONE_PULSE(1'b0)) dut_lvl (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .ciphertext (ct),
      .key        (key),
      .plaintext  (pt_lvl),
      .busy       (busy_lvl),
      .done       (done_lvl)
   );

   aes128_decrypt_iter #(.DONE_PULSE(1'b1)) dut_pls (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .ciphertext (ct),
      .key        (key),
      .plaintext  (pt_pls),
      .busy       (busy_pls),
      .done       (done_pls)
   );

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (x != 0 && gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
         end
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   // Textbook AES-128 encryption over a byte array; decrypting its output must give pt back.
   function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
      logic [7:0]  s [16];
      logic [7:0]  t [16];
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc = 8'h01;
      logic [127:0] out;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) t[row+4*c] = s[row+4*((c+row)%4)];
         for (int c = 0; c < 4; c++) begin
            if (r < 10) begin
               s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
               s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
            end else begin
               for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
            end
            for (int row = 0; row < 4; row++) s[4*c+row] = s[4*c+row] ^ w[4*r+c][31-8*row -: 8];
         end
      end
      for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
      return out;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Returns at the falling edge after the start-sampling edge (edge 0).
   task automatic start_block(input logic [127:0] c, input logic [127:0] k);
      @(negedge clk);
      ct    = c;
      key   = k;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Entered at the falling edge after edge n0 of a block; returns after edge 21.
   task automatic await_result(input string tag, input logic [127:0] exp, input int n0);
      int n  = n0;
      int bc = 0;
      while (!done_lvl && n < 60) begin
         if (busy_lvl) bc++;
         @(negedge clk);
         n++;
      end
      check_val({tag, "_latency"}, 128'(n), 128'(21));
      check_val({tag, "_busy_cycles"}, 128'(bc), 128'(21 - n0));
      check_val({tag, "_busy_end"}, 128'(busy_lvl), 128'(0));
      check_val({tag, "_pt_lvl"}, pt_lvl, exp);
      check_val({tag, "_pt_pls"}, pt_pls, exp);
      check_val({tag, "_done_pls"}, 128'(done_pls), 128'(1));
   endtask

   task automatic check_hold(input string tag, input logic [127:0] exp);
      @(negedge clk);
      check_val({tag, "_pls_cleared"}, 128'(done_pls), 128'(0));
      check_val({tag, "_lvl_held"}, 128'(done_lvl), 128'(1));
      check_val({tag, "_pt_hold"}, pt_pls, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         ign;
      logic [127:0] p, k;
      build_sbox();
      reset = 1'b1;
      start = 1'b0;
      ct    = '0;
      key   = '0;
      repeat (2) @(negedge clk);
      check_val("reset_pt", pt_lvl, 128'h0);
      check_val("reset_busy", {busy_lvl, busy_pls}, 128'h0);
      check_val("reset_done", {done_lvl, done_pls}, 128'h0);
      reset = 1'b0;

      start_block(C1_CT, C1_KEY);
      await_result("c1", C1_PT, 0);
      check_hold("c1", C1_PT);

      start_block(B_CT, B_KEY);
      await_result("appb", B_PT, 0);
      check_hold("appb", B_PT);

      // Start pulsed at edge 5 with another vector must be ignored.
      start_block(Z_CT, 128'h0);
      repeat (4) @(negedge clk);
      ct    = rand128();
      key   = rand128();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      await_result("zero_ign", 128'h0, 5);
      check_hold("zero_ign", 128'h0);

      start_block(C1_CT, C1_KEY);
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_val("abort_busy", {busy_lvl, busy_pls}, 128'h0);
      check_val("abort_done", {done_lvl, done_pls}, 128'h0);
      check_val("abort_pt", pt_lvl, 128'h0);
      @(negedge clk);
      check_val("abort_idle", 128'(busy_lvl), 128'(0));

      start_block(C1_CT, C1_KEY);
      await_result("c1_again", C1_PT, 0);

      // Back-to-back: next block accepted in the first DONE cycle.
      ct    = B_CT;
      key   = B_KEY;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("b2b_done_drop", {done_lvl, done_pls}, 128'h0);
      check_val("b2b_busy", 128'(busy_lvl), 128'(1));
      check_val("b2b_pt_held", pt_pls, C1_PT);
      await_result("b2b", B_PT, 0);
      check_hold("b2b", B_PT);

      for (int i = 0; i < 6; i++) begin
         p = rand128();
         k = rand128();
         start_block(aes_enc(p, k), k);
         ign = 0;
         if (i % 2 == 1) begin
            ign = $urandom_range(1, 18);
            repeat (ign - 1) @(negedge clk);
            ct    = rand128();
            key   = rand128();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         await_result($sformatf("rand%0d", i), p, ign);
         check_hold($sformatf("rand%0d", i), p);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
